mul_issue_ctrl: RTL and testbench

Issue and writeback controller placed directly upstream of the two-register-stage Booth multiplier in the EX/MEM/WB datapath. It accepts MUL requests from EX and drives the multiplier operands and freeze. It tracks the destination register of each in-flight product and presents the finished low 32 bits to the writeback port. It raises a hazard stall toward decode whenever a consumer needs a product that is not yet available.

---
 rtl/mul_issue_ctrl_pkg.sv | 19 +
 rtl/mul_issue_ctrl_if.sv | 41 ++++
 rtl/mul_issue_ctrl_hazard_cmp.sv | 25 ++
 rtl/mul_issue_ctrl.sv | 88 ++++++++
 tb/tb_mul_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and constants for the MUL issue/writeback controller.
// The multiplier reads MUL_LAT to check its own stage count.
package mul_issue_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int MUL_LAT = 2;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
  } trk_entry_t;

  // True when a live tracker entry targets the given nonzero source register.
  function automatic logic trk_hit(trk_entry_t e, logic [RA_W-1:0] rs);
    return e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of EX issue, multiplier, writeback and decode-side signals around the MUL controller.
// master = core/multiplier side, slave = controller side.
interface mul_issue_ctrl_if;
  import mul_issue_ctrl_pkg::*;

  logic            core_stall;
  logic            issue_valid;
  logic            issue_ready;
  logic [RA_W-1:0] issue_rd;
  logic [XLEN-1:0] issue_a;
  logic [XLEN-1:0] issue_b;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic            mul_stall;
  logic [XLEN-1:0] mul_m;
  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic            dec_valid;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic            hazard_stall;
  logic            fwd_rs1_hit;
  logic            fwd_rs2_hit;

  modport master (
    output core_stall, issue_valid, issue_rd, issue_a, issue_b, mul_m,
           wb_ready, dec_valid, dec_rs1, dec_rs2,
    input  issue_ready, mul_a, mul_b, mul_stall, wb_valid, wb_rd, wb_data,
           hazard_stall, fwd_rs1_hit, fwd_rs2_hit
  );

  modport slave (
    input  core_stall, issue_valid, issue_rd, issue_a, issue_b, mul_m,
           wb_ready, dec_valid, dec_rs1, dec_rs2,
    output issue_ready, mul_a, mul_b, mul_stall, wb_valid, wb_rd, wb_data,
           hazard_stall, fwd_rs1_hit, fwd_rs2_hit
  );

endinterface

// File: rtl/mul_issue_ctrl_hazard_cmp.sv
// Compares one decode source register against the issuing request and both tracker stages,
// producing the decode hold and the same-cycle writeback forward hit.
module mul_hazard_cmp
  import mul_issue_ctrl_pkg::*;
(
  input  logic            dec_valid,
  input  logic [RA_W-1:0] rs,
  input  trk_entry_t      iss_ent,
  input  trk_entry_t      s0_ent,
  input  trk_entry_t      s1_hold_ent,
  input  trk_entry_t      s1_commit_ent,
  output logic            stall,
  output logic            fwd_hit
);

  logic rs_live;

  // x0 is hardwired zero, so it never waits on or forwards from a product.
  assign rs_live = dec_valid && (rs != '0);

  assign stall   = rs_live && (trk_hit(iss_ent, rs) || trk_hit(s0_ent, rs) ||
                               trk_hit(s1_hold_ent, rs));
  assign fwd_hit = rs_live && trk_hit(s1_commit_ent, rs);

endmodule

// File: rtl/mul_issue_ctrl.sv
// MUL issue/writeback controller: tracks destination registers alongside the two-stage
// multiplier, freezes it on back-pressure, and flags RAW hazards and forwards toward decode.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  mul_issue_ctrl_if.slave bus
);

  trk_entry_t trk_reg  [MUL_LAT];
  trk_entry_t trk_next [MUL_LAT];

  logic       advance;
  logic       wb_valid_int;
  trk_entry_t iss_ent;
  trk_entry_t s1_hold_ent;
  trk_entry_t s1_commit_ent;

  logic [RA_W-1:0] src_rs    [2];
  logic            src_stall [2];
  logic            src_fwd   [2];

  // An rd==0 product retires silently, so only a real writeback can back-pressure.
  assign wb_valid_int = trk_reg[MUL_LAT-1].valid && (trk_reg[MUL_LAT-1].rd != '0);
  assign advance      = !bus.core_stall && !(wb_valid_int && !bus.wb_ready);

  assign iss_ent.valid = bus.issue_valid;
  assign iss_ent.rd    = bus.issue_rd;

  assign trk_next[0] = iss_ent;

  genvar gi;
  generate
    for (gi = 1; gi < MUL_LAT; gi++) begin : g_shift
      assign trk_next[gi] = trk_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        trk_reg[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        trk_reg[i] <= trk_next[i];
      end
    end
  end

  assign bus.issue_ready = advance;
  assign bus.mul_stall   = !advance;
  assign bus.mul_a       = bus.issue_valid ? bus.issue_a : '0;
  assign bus.mul_b       = bus.issue_valid ? bus.issue_b : '0;

  assign bus.wb_valid = wb_valid_int;
  assign bus.wb_rd    = trk_reg[MUL_LAT-1].rd;
  assign bus.wb_data  = bus.mul_m;

  assign s1_hold_ent.valid   = wb_valid_int && !bus.wb_ready;
  assign s1_hold_ent.rd      = trk_reg[MUL_LAT-1].rd;
  assign s1_commit_ent.valid = wb_valid_int && bus.wb_ready;
  assign s1_commit_ent.rd    = trk_reg[MUL_LAT-1].rd;

  assign src_rs[0] = bus.dec_rs1;
  assign src_rs[1] = bus.dec_rs2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      mul_hazard_cmp u_cmp (
        .dec_valid     (bus.dec_valid),
        .rs            (src_rs[gi]),
        .iss_ent       (iss_ent),
        .s0_ent        (trk_reg[0]),
        .s1_hold_ent   (s1_hold_ent),
        .s1_commit_ent (s1_commit_ent),
        .stall         (src_stall[gi]),
        .fwd_hit       (src_fwd[gi])
      );
    end
  endgenerate

  assign bus.hazard_stall = src_stall[0] || src_stall[1];
  assign bus.fwd_rs1_hit  = src_fwd[0];
  assign bus.fwd_rs2_hit  = src_fwd[1];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural two-stage multiplier that freezes on mul_stall.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  mul_issue_ctrl_if bus ();

  mul_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Two-register multiplier stand-in: low XLEN bits, frozen together with the tracker.
  logic [XLEN-1:0] p0_reg, p1_reg;
  always @(posedge clk) begin
    if (!rst_n) begin
      p0_reg <= '0;
      p1_reg <= '0;
    end else if (!bus.mul_stall) begin
      p0_reg <= bus.mul_a * bus.mul_b;
      p1_reg <= p0_reg;
    end
  end
  assign bus.mul_m = p1_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_stall  = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_a     = '0;
    bus.issue_b     = '0;
    bus.wb_ready    = 1'b1;
    bus.dec_valid   = 1'b0;
    bus.dec_rs1     = '0;
    bus.dec_rs2     = '0;
  endtask

  task automatic issue(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_a     = a;
    bus.issue_b     = b;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.core_stall = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
    n_vec++; if (bus.hazard_stall !== 1'b0) begin n_err++; $display("FAIL reset_hazard got=%b exp=0", bus.hazard_stall); end
    n_vec++; if ({bus.fwd_rs1_hit, bus.fwd_rs2_hit} !== 2'b00) begin n_err++; $display("FAIL reset_fwd got=%b exp=00", {bus.fwd_rs1_hit, bus.fwd_rs2_hit}); end
    n_vec++; if ({bus.issue_ready, bus.mul_stall} !== 2'b01) begin n_err++; $display("FAIL reset_core_stall_ready got=%b exp=01", {bus.issue_ready, bus.mul_stall}); end
    bus.core_stall = 1'b0;
    #1;
    n_vec++; if ({bus.issue_ready, bus.mul_stall} !== 2'b10) begin n_err++; $display("FAIL reset_free_ready got=%b exp=10", {bus.issue_ready, bus.mul_stall}); end
    rst_n = 1'b1;
    $display("reset: tracker cleared, ready follows core_stall");
  endtask

  task automatic test_single();
    idle(); repeat (3) tick();
    issue(5, 32'd7, 32'd6);
    #1;
    n_vec++; if ({bus.issue_ready, bus.mul_stall} !== 2'b10) begin n_err++; $display("FAIL single_accept got=%b exp=10", {bus.issue_ready, bus.mul_stall}); end
    n_vec++; if ({bus.mul_a, bus.mul_b} !== {32'd7, 32'd6}) begin n_err++; $display("FAIL single_operands got=%h/%h exp=7/6", bus.mul_a, bus.mul_b); end
    tick(); idle(); #1;
    n_vec++; if ({bus.mul_a, bus.mul_b} !== 64'd0) begin n_err++; $display("FAIL single_quiet_operands got=%h/%h exp=0/0", bus.mul_a, bus.mul_b); end
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL single_early_wb got=%b exp=0", bus.wb_valid); end
    tick(); #1;
    n_vec++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'd42}) begin n_err++; $display("FAIL single_wb got=%b/%0d/%0d exp=1/5/42", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    n_vec++; if (bus.mul_stall !== 1'b0) begin n_err++; $display("FAIL single_no_stall got=%b exp=0", bus.mul_stall); end
    tick(); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL single_wb_clear got=%b exp=0", bus.wb_valid); end
    $display("single: rd=5 7*6 -> %0d", 42);
  endtask

  task automatic test_back_to_back();
    logic [RA_W-1:0] exp_rd   [3];
    logic [XLEN-1:0] exp_data [3];
    exp_rd   = '{5'd1, 5'd2, 5'd3};
    exp_data = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000};
    idle(); repeat (3) tick();
    issue(1, 32'hFFFF_FFFF, 32'd2); tick();
    issue(2, 32'h0001_0000, 32'h0001_0000); tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) issue(3, 32'd0, 32'd9);
      else        idle();
      #1;
      n_vec++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, exp_rd[k], exp_data[k]}) begin n_err++; $display("FAIL b2b_wb%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.wb_valid, bus.wb_rd, bus.wb_data, exp_rd[k], exp_data[k]); end
      $display("b2b: wb rd=%0d data=%h", bus.wb_rd, bus.wb_data);
      tick();
    end
    #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_backpressure();
    idle(); repeat (3) tick();
    issue(4, 32'd3, 32'd5); tick();
    idle(); tick();
    for (int k = 0; k < 2; k++) begin
      bus.wb_ready  = 1'b0;
      bus.dec_valid = 1'b1;
      bus.dec_rs2   = 5'd4;
      #1;
      n_vec++; if ({bus.mul_stall, bus.issue_ready} !== 2'b10) begin n_err++; $display("FAIL bp_stall%0d got=%b exp=10", k, {bus.mul_stall, bus.issue_ready}); end
      n_vec++; if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'd15}) begin n_err++; $display("FAIL bp_hold%0d got=%b/%0d exp=1/15", k, bus.wb_valid, bus.wb_data); end
      n_vec++; if ({bus.hazard_stall, bus.fwd_rs2_hit} !== 2'b10) begin n_err++; $display("FAIL bp_hazard%0d got=%b exp=10", k, {bus.hazard_stall, bus.fwd_rs2_hit}); end
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    n_vec++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd4, 32'd15}) begin n_err++; $display("FAIL bp_commit got=%b/%0d/%0d exp=1/4/15", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    n_vec++; if ({bus.hazard_stall, bus.fwd_rs2_hit, bus.issue_ready} !== 3'b011) begin n_err++; $display("FAIL bp_fwd got=%b exp=011", {bus.hazard_stall, bus.fwd_rs2_hit, bus.issue_ready}); end
    tick(); idle(); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", bus.wb_valid); end
    $display("backpressure: rd=4 held two cycles, committed 15");
  endtask

  task automatic test_core_stall();
    idle(); repeat (3) tick();
    issue(6, 32'd10, 32'd10); tick();
    idle(); tick();
    bus.core_stall = 1'b1;
    #1;
    n_vec++; if ({bus.mul_stall, bus.issue_ready, bus.wb_valid} !== 3'b101) begin n_err++; $display("FAIL cs_freeze got=%b exp=101", {bus.mul_stall, bus.issue_ready, bus.wb_valid}); end
    tick();
    bus.core_stall = 1'b0;
    #1;
    n_vec++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd6, 32'd100}) begin n_err++; $display("FAIL cs_represent got=%b/%0d/%0d exp=1/6/100", bus.wb_valid, bus.wb_rd, bus.wb_data); end
    tick(); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL cs_drain got=%b exp=0", bus.wb_valid); end
    $display("core_stall: rd=6 writeback re-presented after freeze");
  endtask

  task automatic test_raw_hazard();
    idle(); repeat (3) tick();
    issue(8, 32'd4, 32'd4);
    bus.dec_valid = 1'b1;
    bus.dec_rs1   = 5'd8;
    bus.dec_rs2   = 5'd9;
    #1;
    n_vec++; if ({bus.hazard_stall, bus.fwd_rs1_hit} !== 2'b10) begin n_err++; $display("FAIL raw_c0 got=%b exp=10", {bus.hazard_stall, bus.fwd_rs1_hit}); end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_vec++; if ({bus.hazard_stall, bus.fwd_rs1_hit} !== 2'b10) begin n_err++; $display("FAIL raw_c1 got=%b exp=10", {bus.hazard_stall, bus.fwd_rs1_hit}); end
    tick(); #1;
    n_vec++; if ({bus.hazard_stall, bus.fwd_rs1_hit, bus.fwd_rs2_hit} !== 3'b010) begin n_err++; $display("FAIL raw_c2 got=%b exp=010", {bus.hazard_stall, bus.fwd_rs1_hit, bus.fwd_rs2_hit}); end
    n_vec++; if (bus.wb_data !== 32'd16) begin n_err++; $display("FAIL raw_data got=%0d exp=16", bus.wb_data); end
    $display("raw: rs1=8 stalled two cycles, forwarded %0d", 16);
    idle(); repeat (3) tick();
    issue(8, 32'd2, 32'd3);
    bus.dec_valid = 1'b1;
    bus.dec_rs1   = 5'd0;
    bus.dec_rs2   = 5'd0;
    #1;
    n_vec++; if (bus.hazard_stall !== 1'b0) begin n_err++; $display("FAIL raw_x0_c0 got=%b exp=0", bus.hazard_stall); end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_vec++; if (bus.hazard_stall !== 1'b0) begin n_err++; $display("FAIL raw_x0_c1 got=%b exp=0", bus.hazard_stall); end
    $display("raw: rs1=0 never stalls");
  endtask

  task automatic test_rd0();
    idle(); repeat (3) tick();
    bus.wb_ready = 1'b0;
    issue(0, 32'd3, 32'd3);
    bus.dec_valid = 1'b1;
    bus.dec_rs1   = 5'd1;
    #1;
    n_vec++; if ({bus.hazard_stall, bus.issue_ready} !== 2'b01) begin n_err++; $display("FAIL rd0_c0 got=%b exp=01", {bus.hazard_stall, bus.issue_ready}); end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_vec++; if ({bus.wb_valid, bus.hazard_stall} !== 2'b00) begin n_err++; $display("FAIL rd0_c1 got=%b exp=00", {bus.wb_valid, bus.hazard_stall}); end
    tick(); #1;
    n_vec++; if ({bus.wb_valid, bus.issue_ready, bus.mul_stall} !== 3'b010) begin n_err++; $display("FAIL rd0_c2 got=%b exp=010", {bus.wb_valid, bus.issue_ready, bus.mul_stall}); end
    tick(); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rd0_c3 got=%b exp=0", bus.wb_valid); end
    $display("rd0: silent completion with wb_ready low");
  endtask

  task automatic test_reset_midflight();
    idle(); repeat (3) tick();
    issue(7, 32'd5, 32'd5); tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.dec_valid = 1'b1;
    bus.dec_rs1   = 5'd7;
    #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_wb got=%b exp=0", bus.wb_valid); end
    n_vec++; if ({bus.hazard_stall, bus.fwd_rs1_hit, bus.fwd_rs2_hit, bus.issue_ready} !== 4'b0001) begin n_err++; $display("FAIL rst_mid_outs got=%b exp=0001", {bus.hazard_stall, bus.fwd_rs1_hit, bus.fwd_rs2_hit, bus.issue_ready}); end
    tick(); #1;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_late_wb got=%b exp=0", bus.wb_valid); end
    $display("reset_midflight: rd=7 product discarded");
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_core_stall();
    test_raw_hazard();
    test_rd0();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
